counter_stream_checker: RTL and testbench

Receive-side checker for the synchronous odd/even counter stream. It samples the counter value bus, infers the active mode from value parity, and verifies every sample against the counter's sequencing rules: +2 modulo 2^CNT_WIDTH, restart at 1 for odd mode and at 0 for even mode. It reports mode, lock status, mode-switch/restart events and a saturating error count. It sits at the consuming end of the counter output, in system integration or as an in-design monitor.

---
 rtl/counter_defs_pkg.sv | 14 +
 rtl/sat_counter.sv | 24 ++
 rtl/counter_stream_checker.sv | 95 +++++++++
 tb/tb_counter_stream_checker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_defs_pkg.sv
// Shared constants for the odd/even counter and its stream checker.
// Restart values, step size and checker state encodings live here.
package counter_defs;

    localparam int ODD_RESTART  = 1;
    localparam int EVEN_RESTART = 0;
    localparam int STEP         = 2;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Cleared by a synchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Inc,
    output logic [WIDTH-1:0] Value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_value <= '0;
        end else if (Inc && (r_value != '1)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign Value = r_value;

endmodule

// File: rtl/counter_stream_checker.sv
// Receive-side checker for the odd/even +2 counter stream: infers mode from
// parity, classifies each sample as step, restart or error, and tracks lock.
import counter_defs::*;

module counter_stream_checker #(
    parameter int CNT_WIDTH   = 4,
    parameter int ERR_WIDTH   = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [CNT_WIDTH-1:0] CounterIn,
    input  logic                 Valid,
    output logic                 Mode,
    output logic                 Locked,
    output logic                 Restart,
    output logic                 Error,
    output logic [ERR_WIDTH-1:0] ErrorCount
);

    state_t               r_state;
    state_t               w_nextState;
    logic [CNT_WIDTH-1:0] r_prev;
    logic                 r_mode;
    logic                 r_restart;
    logic                 r_error;
    logic [3:0]           r_consec;

    logic [CNT_WIDTH-1:0] w_exp;
    logic [CNT_WIDTH-1:0] w_restartVal;
    logic                 w_tracking;
    logic                 w_isStep;
    logic                 w_isRestart;
    logic                 w_isError;
    logic                 w_lossHit;

    // Expected step wins over restart so wrap-around (15->1, 14->0) is a plain step.
    assign w_exp        = r_prev + CNT_WIDTH'(STEP);
    assign w_restartVal = CounterIn[0] ? CNT_WIDTH'(ODD_RESTART) : CNT_WIDTH'(EVEN_RESTART);
    assign w_tracking   = Valid && (r_state == TRACK);
    assign w_isStep     = w_tracking && (CounterIn == w_exp);
    assign w_isRestart  = w_tracking && !w_isStep && (CounterIn == w_restartVal);
    assign w_isError    = w_tracking && !w_isStep && !w_isRestart;
    assign w_lossHit    = w_isError && (r_consec == 4'(LOSS_THRESH - 1));

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            HUNT:    if (Valid) w_nextState = TRACK;
            TRACK:   if (w_lossHit) w_nextState = HUNT;
            default: w_nextState = HUNT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= HUNT;
            r_prev    <= '0;
            r_mode    <= 1'b0;
            r_restart <= 1'b0;
            r_error   <= 1'b0;
            r_consec  <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_restart <= w_isRestart;
            r_error   <= w_isError;
            if (Valid) begin
                r_prev <= CounterIn;
            end
            if ((Valid && (r_state == HUNT)) || w_isRestart) begin
                r_mode <= CounterIn[0];
            end
            if (w_isError) begin
                r_consec <= w_lossHit ? 4'd0 : r_consec + 4'd1;
            end else if (w_tracking) begin
                r_consec <= 4'd0;
            end
        end
    end

    sat_counter #(
        .WIDTH(ERR_WIDTH)
    ) u_errCount (
        .Clk  (Clk),
        .Reset(Reset),
        .Inc  (w_isError),
        .Value(ErrorCount)
    );

    assign Mode    = r_mode;
    assign Locked  = (r_state == TRACK);
    assign Restart = r_restart;
    assign Error   = r_error;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Self-checking bench for counter_stream_checker: a rule-level model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_counter_stream_checker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] CounterIn = 4'd0;
    logic       Valid = 1'b0;

    logic       modeA, lockedA, restartA, errorA;
    logic [7:0] errCountA;
    logic       modeB, lockedB, restartB, errorB;
    logic [1:0] errCountB;

    int checks = 0;
    int errors = 0;
    bit compareEn = 0;

    // Model state, kept as plain integers following the sequencing rules
    int  mLocked = 0, mMode = 0, mPrev = 0, mConsec = 0;
    int  mRestart = 0, mError = 0, mErrA = 0, mErrB = 0;

    always #5 Clk = ~Clk;

    counter_stream_checker #(.CNT_WIDTH(4), .ERR_WIDTH(8), .LOSS_THRESH(3)) dutA (
        .Clk(Clk), .Reset(Reset), .CounterIn(CounterIn), .Valid(Valid),
        .Mode(modeA), .Locked(lockedA), .Restart(restartA), .Error(errorA),
        .ErrorCount(errCountA)
    );

    counter_stream_checker #(.CNT_WIDTH(4), .ERR_WIDTH(2), .LOSS_THRESH(3)) dutB (
        .Clk(Clk), .Reset(Reset), .CounterIn(CounterIn), .Valid(Valid),
        .Mode(modeB), .Locked(lockedB), .Restart(restartB), .Error(errorB),
        .ErrorCount(errCountB)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Rule-level model: expected outputs after each rising edge
    always @(posedge Clk) begin
        int expv;
        int rv;
        int s;
        s = int'(CounterIn);
        mRestart = 0;
        mError   = 0;
        if (Reset) begin
            mLocked = 0; mMode = 0; mPrev = 0; mConsec = 0; mErrA = 0; mErrB = 0;
        end else if (Valid) begin
            if (mLocked == 0) begin
                mMode   = s % 2;
                mLocked = 1;
            end else begin
                expv = (mPrev + 2) % 16;
                rv   = (s % 2 == 1) ? 1 : 0;
                if (s == expv) begin
                    mConsec = 0;
                end else if (s == rv) begin
                    mRestart = 1;
                    mMode    = s % 2;
                    mConsec  = 0;
                end else begin
                    mError = 1;
                    if (mErrA < 255) mErrA++;
                    if (mErrB < 3) mErrB++;
                    mConsec++;
                    if (mConsec == 3) begin
                        mLocked = 0;
                        mConsec = 0;
                    end
                end
            end
            mPrev = s;
        end
    end

    // Compare both DUTs against the model on every falling edge
    always @(negedge Clk) begin
        if (compareEn) begin
            checkOutput("modeA", int'(modeA), mMode);
            checkOutput("lockedA", int'(lockedA), mLocked);
            checkOutput("restartA", int'(restartA), mRestart);
            checkOutput("errorA", int'(errorA), mError);
            checkOutput("errCountA", int'(errCountA), mErrA);
            checkOutput("modeB", int'(modeB), mMode);
            checkOutput("lockedB", int'(lockedB), mLocked);
            checkOutput("restartB", int'(restartB), mRestart);
            checkOutput("errorB", int'(errorB), mError);
            checkOutput("errCountB", int'(errCountB), mErrB);
        end
    end

    task automatic applyStimulus(input bit rst, input bit v, input int val);
        Reset     = rst;
        Valid     = v;
        CounterIn = 4'(val);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Valid = 1'b0;
    endtask

    task automatic sample(input int val);
        applyStimulus(1'b0, 1'b1, val);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0);
    endtask

    initial begin
        doReset();
        compareEn = 1;
        checkOutput("lit_reset_locked", int'(lockedA), 0);
        checkOutput("lit_reset_errcnt", int'(errCountA), 0);

        // Even stream with wrap 14 -> 0
        sample(0);
        checkOutput("lit_s1_locked", int'(lockedA), 1);
        for (int i = 1; i < 8; i++) sample(2 * i);
        sample(0);
        checkOutput("lit_s1_wrap_restart", int'(restartA), 0);
        sample(2);
        checkOutput("lit_s1_errcnt", int'(errCountA), 0);

        // Mode switch even -> odd
        doReset();
        sample(0); sample(2); sample(4);
        sample(1);
        checkOutput("lit_s2_restart", int'(restartA), 1);
        checkOutput("lit_s2_mode", int'(modeA), 1);
        sample(3); sample(5);
        checkOutput("lit_s2_noerr", int'(errorA), 0);

        // Same-mode restart, then odd wrap 15 -> 1
        doReset();
        sample(9); sample(11); sample(1);
        checkOutput("lit_s2b_restart", int'(restartA), 1);
        doReset();
        sample(13); sample(15); sample(1);
        checkOutput("lit_wrap_odd_restart", int'(restartA), 0);
        sample(3);

        // One corrupted sample yields two errors, then resync
        doReset();
        sample(1); sample(3);
        sample(9);
        checkOutput("lit_s3_err1", int'(errorA), 1);
        sample(7);
        checkOutput("lit_s3_err2", int'(errorA), 1);
        sample(9); sample(11);
        checkOutput("lit_s3_errcnt", int'(errCountA), 2);
        checkOutput("lit_s3_locked", int'(lockedA), 1);

        // Lock loss after three consecutive errors, then reacquire
        doReset();
        sample(0); sample(2); sample(9); sample(5); sample(13);
        checkOutput("lit_s4_err", int'(errorA), 1);
        checkOutput("lit_s4_unlocked", int'(lockedA), 0);
        sample(4);
        checkOutput("lit_s4_relock", int'(lockedA), 1);
        checkOutput("lit_s4_mode", int'(modeA), 0);

        // Gaps are legal; error counter saturation on the narrow instance
        doReset();
        sample(0); sample(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 15);
        sample(4);
        checkOutput("lit_s5_gap_noerr", int'(errorA), 0);
        sample(10); sample(3); sample(7);
        sample(8); sample(3); sample(9); sample(2);
        checkOutput("lit_s5_errcntA", int'(errCountA), 6);
        checkOutput("lit_s5_errcntB", int'(errCountB), 3);

        // Reset together with a valid sample drops the sample
        doReset();
        sample(0); sample(2); sample(4);
        applyStimulus(1'b1, 1'b1, 6);
        checkOutput("lit_s6_locked", int'(lockedA), 0);
        checkOutput("lit_s6_mode", int'(modeA), 0);
        sample(7);
        checkOutput("lit_s6_relock", int'(lockedA), 1);
        checkOutput("lit_s6_mode_odd", int'(modeA), 1);
        sample(9);
        checkOutput("lit_s6_noerr", int'(errorA), 0);

        @(negedge Clk);
        compareEn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
